spis_avmm_seq: RTL and testbench

- Slave-side AVMM command sequencer for the SPI slave register/buffer block.
- Consumes the decoded s_cmd fields (valid, read-not-write, burst length, select, offset) and runs the burst on the AVMM master port.
- Write bursts pop the write buffer; read bursts push returned data into the read buffer.
- Signals completion with avmmtransvld_up, which clears the command valid bit.

---
 rtl/spis_avmm_seq.sv | 215 +++++++++++++++++++++
 tb/tb_spis_avmm_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spis_avmm_seq.sv
// AVMM command sequencer for the SPI slave register/buffer block.
// Optional stall timeout: define SPIS_AVMM_SEQ_TIMEOUT_EN.
module spis_avmm_seq #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [15:0] WBUF_BASE   = 16'h0200,
  parameter logic [15:0] RBUF_BASE   = 16'h1000
) (
  input  logic        s_avmm_clk,
  input  logic        s_avmm_rst,
  input  logic        avmm_transvld,
  input  logic        avmm_rdnwr,
  input  logic [7:0]  avmm_brstlen,
  input  logic [1:0]  avmm_sel,
  input  logic [16:0] avmm_offset,
  input  logic        wbuf_rd_empty,
  input  logic [31:0] reg_wdata,
  output logic        reg_read_pulse,
  output logic        reg_write,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_rdata,
  output logic        avmmtransvld_up,
  output logic [1:0]  m_avmm_sel,
  output logic [18:0] m_avmm_address,
  output logic        m_avmm_write,
  output logic        m_avmm_read,
  output logic [31:0] m_avmm_writedata,
  input  logic        m_avmm_waitrequest,
  input  logic [31:0] m_avmm_readdata,
  input  logic        m_avmm_readdatavalid,
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
  output logic        seq_timeout_err,
`endif
  output logic        seq_busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR_POP,
    WR_DATA,
    RD_REQ,
    RD_WAIT,
    RD_PUSH,
    DONE,
    DONE_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [16:0] off_q, off_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        last_beat;

  assign last_beat = (idx_q == last_q);

`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
  logic [15:0] stall_q, stall_d;
  logic        terr_q, terr_d;
  logic        tmo;
  assign tmo = (stall_q == 16'(TIMEOUT_CYC - 1));
  assign seq_timeout_err = terr_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // State and burst context registers.
  always_ff @(posedge s_avmm_clk or posedge s_avmm_rst) begin
    if (s_avmm_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      off_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
      stall_q <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
      stall_q <= stall_d;
      terr_q  <= terr_d;
`endif
    end
  end

  // Next-state, beat bookkeeping and per-state strobes.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    off_d           = off_q;
    last_d          = last_q;
    idx_d           = idx_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    reg_read_pulse  = 1'b0;
    reg_write       = 1'b0;
    reg_addr        = '0;
    avmmtransvld_up = 1'b0;
    m_avmm_write    = 1'b0;
    m_avmm_read     = 1'b0;
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
    terr_d          = terr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (avmm_transvld) begin
          sel_d   = avmm_sel;
          off_d   = avmm_offset;
          last_d  = avmm_brstlen;
          idx_d   = '0;
          state_d = avmm_rdnwr ? RD_REQ : WR_POP;
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      WR_POP: begin
        if (!wbuf_rd_empty) begin
          reg_read_pulse = 1'b1;
          reg_addr       = WBUF_BASE + {8'd0, idx_q};
          wdata_d        = reg_wdata;
          state_d        = WR_DATA;
        end
      end
      WR_DATA: begin
        m_avmm_write = 1'b1;
        if (!m_avmm_waitrequest) begin
          idx_d   = idx_q + 8'd1;
          off_d   = off_q + 17'd1;
          state_d = last_beat ? DONE : WR_POP;
        end
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
        else if (tmo) begin
          state_d = DONE;
          terr_d  = 1'b1;
        end
`endif
      end
      RD_REQ: begin
        m_avmm_read = 1'b1;
        if (!m_avmm_waitrequest) begin
          if (m_avmm_readdatavalid) begin
            rdata_d = m_avmm_readdata;
            state_d = RD_PUSH;
          end else begin
            state_d = RD_WAIT;
          end
        end
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
        else if (tmo) begin
          state_d = DONE;
          terr_d  = 1'b1;
        end
`endif
      end
      RD_WAIT: begin
        if (m_avmm_readdatavalid) begin
          rdata_d = m_avmm_readdata;
          state_d = RD_PUSH;
        end
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
        else if (tmo) begin
          state_d = DONE;
          terr_d  = 1'b1;
        end
`endif
      end
      RD_PUSH: begin
        reg_write = 1'b1;
        reg_addr  = RBUF_BASE + {8'd0, idx_q};
        idx_d     = idx_q + 8'd1;
        off_d     = off_q + 17'd1;
        state_d   = last_beat ? DONE : RD_REQ;
      end
      DONE: begin
        avmmtransvld_up = 1'b1;
        state_d         = DONE_WAIT;
      end
      DONE_WAIT: begin
        if (!avmm_transvld) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
  // Stall counter restarts on every state entry.
  always_comb begin
    stall_d = '0;
    if (state_d == state_q &&
        (state_q == WR_DATA || state_q == RD_REQ ||
         state_q == RD_WAIT))
      stall_d = stall_q + 16'd1;
  end
`endif

  assign reg_rdata        = rdata_q;
  assign m_avmm_sel       = sel_q;
  assign m_avmm_address   = {off_q, 2'b00};
  assign m_avmm_writedata = wdata_q;
  assign seq_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spis_avmm_seq.sv
// Directed bench for spis_avmm_seq with buffer and AVMM slave models.
// Covers write/read bursts, stalls, offset wrap, stale valid, reset.
module tb_spis_avmm_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        transvld = 1'b0;
  logic        rdnwr = 1'b0;
  logic [7:0]  brstlen = '0;
  logic [1:0]  sel = '0;
  logic [16:0] offset = '0;
  logic        empty;
  logic [31:0] wdata_in;
  logic        waitreq;
  logic [31:0] rdat = '0;
  logic        rvalid;

  logic        reg_read_pulse, reg_write, avmmtransvld_up;
  logic [15:0] reg_addr;
  logic [31:0] reg_rdata, m_wdata;
  logic [1:0]  m_sel;
  logic [18:0] m_addr;
  logic        m_write, m_read, seq_busy;
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
  logic        seq_timeout_err;
`endif

  always #5 clk = ~clk;

  spis_avmm_seq dut (
    .s_avmm_clk          (clk),
    .s_avmm_rst          (rst),
    .avmm_transvld       (transvld),
    .avmm_rdnwr          (rdnwr),
    .avmm_brstlen        (brstlen),
    .avmm_sel            (sel),
    .avmm_offset         (offset),
    .wbuf_rd_empty       (empty),
    .reg_wdata           (wdata_in),
    .reg_read_pulse      (reg_read_pulse),
    .reg_write           (reg_write),
    .reg_addr            (reg_addr),
    .reg_rdata           (reg_rdata),
    .avmmtransvld_up     (avmmtransvld_up),
    .m_avmm_sel          (m_sel),
    .m_avmm_address      (m_addr),
    .m_avmm_write        (m_write),
    .m_avmm_read         (m_read),
    .m_avmm_writedata    (m_wdata),
    .m_avmm_waitrequest  (waitreq),
    .m_avmm_readdata     (rdat),
    .m_avmm_readdatavalid(rvalid),
`ifdef SPIS_AVMM_SEQ_TIMEOUT_EN
    .seq_timeout_err     (seq_timeout_err),
`endif
    .seq_busy            (seq_busy)
  );

  int chk = 0;
  int err = 0;

  // Write buffer model
  logic [31:0] wdat [16];
  int wcnt = 0;
  int wh;
  // AVMM slave model
  int stall_n = 0;
  int scnt;
  int rd_lat = 0;
  int rcnt;
  int cyc = 0;

  assign empty    = (wh >= wcnt);
  assign wdata_in = wdat[wh[3:0]];
  assign waitreq  = (m_write || m_read) && (scnt < stall_n);
  assign rvalid   = (rd_lat == 0) ? (m_read && !waitreq)
                                  : (rcnt == 1);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wh   <= 0;
      scnt <= 0;
      rcnt <= 0;
    end else begin
      if (reg_read_pulse) wh <= wh + 1;
      if ((m_write || m_read) && waitreq) scnt <= scnt + 1;
      else if (m_write || m_read) scnt <= 0;
      if (m_read && !waitreq && rd_lat > 0) rcnt <= rd_lat;
      else if (rcnt > 0) rcnt <= rcnt - 1;
    end
  end

  // Event log
  logic [15:0] pa [64];
  logic [18:0] wa [64];
  logic [31:0] wd [64];
  logic [15:0] ra [64];
  logic [31:0] rd [64];
  int rwc [64];
  int np = 0, nw = 0, nr = 0, nu = 0, upc = 0;
  int nstall = 0, unstable = 0, badpop = 0, nboth = 0;
  logic        pstall = 1'b0;
  logic [18:0] paddr = '0;
  logic [31:0] pdata = '0;

  always @(negedge clk) begin
    if (reg_read_pulse) begin
      if (empty) badpop++;
      if (np < 64) pa[np] = reg_addr;
      np++;
    end
    if (m_write && !waitreq) begin
      if (nw < 64) begin
        wa[nw] = m_addr;
        wd[nw] = m_wdata;
      end
      nw++;
    end
    if (reg_write) begin
      if (nr < 64) begin
        ra[nr]  = reg_addr;
        rd[nr]  = reg_rdata;
        rwc[nr] = cyc;
      end
      nr++;
    end
    if (avmmtransvld_up) begin
      nu++;
      upc = cyc;
    end
    if (m_write && waitreq) nstall++;
    if (m_write && m_read) nboth++;
    if (pstall && !(m_write && m_addr == paddr && m_wdata == pdata))
      unstable++;
    pstall = m_write && waitreq;
    paddr  = m_addr;
    pdata  = m_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [31:0] obs,
                    input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic rnw, input logic [7:0] bl,
                        input logic [16:0] off, input logic [1:0] s);
    transvld = 1'b1;
    rdnwr    = rnw;
    brstlen  = bl;
    offset   = off;
    sel      = s;
  endtask

  task automatic wait_up(input int lim);
    int n = 0;
    while (!avmmtransvld_up && n < lim) begin
      tick();
      n++;
    end
    ck("up_seen", 32'(avmmtransvld_up), 32'd1);
  endtask

  int np0, nw0, nr0, nu0, ns0;

  initial begin
    for (int i = 0; i < 16; i++) wdat[i] = 32'hA000_0000 + 32'(i * 17);

    tick();
    tick();
    ck("rst_busy", 32'(seq_busy), 0);
    ck("rst_wr", 32'(m_write), 0);
    ck("rst_rd", 32'(m_read), 0);
    ck("rst_addr", 32'(m_addr), 0);
    ck("rst_wdata", m_wdata, 0);
    ck("rst_regaddr", 32'(reg_addr), 0);
    ck("rst_up", 32'(avmmtransvld_up), 0);
    rst = 1'b0;
    tick();

    // Write burst of 4, offset 0x10
    np0 = np; nw0 = nw; nu0 = nu;
    wcnt = 4;
    launch(1'b0, 8'd3, 17'h10, 2'd1);
    wait_up(100);
    transvld = 1'b0;
    tick();
    tick();
    ck("t1_pops", 32'(np - np0), 4);
    ck("t1_writes", 32'(nw - nw0), 4);
    for (int i = 0; i < 4; i++) begin
      ck("t1_popaddr", 32'(pa[np0+i]), 32'h200 + 32'(i));
      ck("t1_waddr", 32'(wa[nw0+i]), 32'h40 + 32'(4 * i));
      ck("t1_wdata", wd[nw0+i], wdat[i]);
    end
    ck("t1_ups", 32'(nu - nu0), 1);
    ck("t1_sel", 32'(m_sel), 1);
    ck("t1_idle", 32'(seq_busy), 0);

    // Single read, data 5 cycles after accept
    nr0 = nr; nu0 = nu;
    rd_lat = 5;
    rdat = 32'hCAFE_F00D;
    launch(1'b1, 8'd0, 17'h8, 2'd0);
    wait_up(100);
    transvld = 1'b0;
    tick();
    tick();
    ck("t2_pushes", 32'(nr - nr0), 1);
    ck("t2_raddr", 32'(ra[nr0]), 32'h1000);
    ck("t2_rdata", rd[nr0], 32'hCAFE_F00D);
    ck("t2_uplat", 32'(upc - rwc[nr0]), 1);
    ck("t2_ups", 32'(nu - nu0), 1);
    ck("t2_addr", 32'(m_addr), 32'h24);

    // Write with empty buffer then 3 stall cycles per beat
    np0 = np; nw0 = nw; ns0 = nstall;
    stall_n = 3;
    launch(1'b0, 8'd1, 17'h20, 2'd2);
    repeat (20) tick();
    ck("t3_nopop", 32'(np - np0), 0);
    ck("t3_nowrite", 32'(nw - nw0), 0);
    ck("t3_busy", 32'(seq_busy), 1);
    ck("t3_wrlow", 32'(m_write), 0);
    wcnt = 6;
    wait_up(200);
    transvld = 1'b0;
    tick();
    tick();
    ck("t3_pops", 32'(np - np0), 2);
    ck("t3_writes", 32'(nw - nw0), 2);
    ck("t3_waddr0", 32'(wa[nw0]), 32'h80);
    ck("t3_waddr1", 32'(wa[nw0+1]), 32'h84);
    ck("t3_wdata0", wd[nw0], wdat[4]);
    ck("t3_wdata1", wd[nw0+1], wdat[5]);
    ck("t3_stalls", 32'(nstall - ns0), 6);
    ck("t3_stable", 32'(unstable), 0);
    ck("t3_badpop", 32'(badpop), 0);

    // Offset wrap, valid held high after completion
    np0 = np; nw0 = nw; nu0 = nu;
    stall_n = 0;
    wcnt = 8;
    launch(1'b0, 8'd1, 17'h1FFFF, 2'd3);
    wait_up(100);
    repeat (10) tick();
    ck("t4_waddr0", 32'(wa[nw0]), 32'h7FFFC);
    ck("t4_waddr1", 32'(wa[nw0+1]), 32'h0);
    ck("t4_wdata1", wd[nw0+1], wdat[7]);
    ck("t4_ups", 32'(nu - nu0), 1);
    ck("t4_norelaunch", 32'(np - np0), 2);
    ck("t4_busyhold", 32'(seq_busy), 1);
    transvld = 1'b0;
    tick();
    tick();
    ck("t4_idle", 32'(seq_busy), 0);

    // Reset in the middle of a read
    rd_lat = 20;
    launch(1'b1, 8'd0, 17'h55, 2'd2);
    repeat (5) tick();
    ck("t5_busy", 32'(seq_busy), 1);
    ck("t5_addr", 32'(m_addr), 32'h154);
    rst = 1'b1;
    #1;
    ck("t5_rbusy", 32'(seq_busy), 0);
    ck("t5_rread", 32'(m_read), 0);
    ck("t5_raddr", 32'(m_addr), 0);
    ck("t5_rsel", 32'(m_sel), 0);
    ck("t5_rregw", 32'(reg_write), 0);
    ck("t5_rup", 32'(avmmtransvld_up), 0);
    transvld = 1'b0;
    tick();
    rst = 1'b0;
    repeat (25) tick();

    // Two-beat read with same-cycle read data
    nr0 = nr;
    rd_lat = 0;
    rdat = 32'h1234_5678;
    launch(1'b1, 8'd1, 17'h100, 2'd0);
    wait_up(100);
    transvld = 1'b0;
    tick();
    tick();
    ck("t6_pushes", 32'(nr - nr0), 2);
    ck("t6_raddr0", 32'(ra[nr0]), 32'h1000);
    ck("t6_raddr1", 32'(ra[nr0+1]), 32'h1001);
    ck("t6_rdata1", rd[nr0+1], 32'h1234_5678);
    ck("t6_beatlat", 32'(rwc[nr0+1] - rwc[nr0]), 2);
    ck("t6_uplat", 32'(upc - rwc[nr0+1]), 1);
    ck("no_rd_wr_overlap", 32'(nboth), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
